// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: per-output scheduler for the wormhole router.
// Round-robin between packets, locked to one input from head to tail,
// gated by a downstream credit counter. Turn-disable applies only when
// choosing a new packet.

// One requesting input: eligibility and final grant gating.
module noc_oarb_lane (
  input  logic req,
  input  logic dis,
  input  logic sel,
  input  logic cr_ok,
  input  logic blk,
  output logic elig,
  output logic grant
);
  // An input may win a new packet only if the turn to this output is allowed.
  // The grant needs the selector, a live request, a credit, and no reset.
  always_comb begin
    elig  = req & ~dis;
    grant = sel & req & cr_ok & ~blk;
  end
endmodule

module noc_output_arbiter #(
  parameter int NUM_INPUTS   = 5,
  parameter int CREDIT_COUNT = 4,
  parameter int IDX_WIDTH    = $clog2(NUM_INPUTS),
  parameter int CNT_WIDTH    = $clog2(CREDIT_COUNT + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic [NUM_INPUTS-1:0] disable_in,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send_out,
  output logic                  is_tail_out,
  output logic                  locked,
  output logic [IDX_WIDTH-1:0]  owner,
  output logic [CNT_WIDTH-1:0]  credits,
  output logic                  overflow_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] CR_MAX   = CNT_WIDTH'(CREDIT_COUNT);

  logic [0:0]           state_q,    state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IDX_WIDTH-1:0] owner_q,    owner_d;
  logic [CNT_WIDTH-1:0] credits_q,  credits_d;
  logic                 overflow_q, overflow_d;

  logic [NUM_INPUTS-1:0] elig;
  logic [NUM_INPUTS-1:0] sel;
  logic [NUM_INPUTS-1:0] gnt;
  logic [NUM_INPUTS-1:0] owner_oh;
  logic [NUM_INPUTS-1:0] win_oh;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic                  win_vld;
  logic                  cr_ok;
  logic                  send;
  logic                  gnt_tail;

  function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  assign cr_ok = (credits_q != '0);

  // Round-robin search: first eligible index at or above rr_ptr, wrapping.
  always_comb begin
    logic [IDX_WIDTH-1:0] p;
    p       = rr_ptr_q;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!win_vld && elig[p]) begin
        win_vld = 1'b1;
        win_idx = p;
      end
      p = idx_inc(p);
    end
  end

  // One-hot decodes of the search winner and the locked owner.
  always_comb begin
    win_oh   = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      win_oh[i]   = win_vld && (win_idx == IDX_WIDTH'(i));
      owner_oh[i] = (owner_q == IDX_WIDTH'(i));
    end
  end

  // Mid-packet only the owner may go; otherwise the arbitration winner.
  always_comb begin
    sel = (state_q == ST_LOCKED) ? owner_oh : win_oh;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      noc_oarb_lane u_lane (
        .req   (req[gi]),
        .dis   (disable_in[gi]),
        .sel   (sel[gi]),
        .cr_ok (cr_ok),
        .blk   (rst_noc_sync),
        .elig  (elig[gi]),
        .grant (gnt[gi])
      );
    end
  endgenerate

  // Combinational outputs for the flit leaving this cycle.
  always_comb begin
    send     = |gnt;
    gnt_tail = |(gnt & req_is_tail);
  end

  // Packet FSM and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (state_q == ST_IDLE) begin
      if (send) begin
        if (gnt_tail) begin
          rr_ptr_d = idx_inc(win_idx);
        end else begin
          state_d = ST_LOCKED;
          owner_d = win_idx;
        end
      end
    end else begin
      if (send && gnt_tail) begin
        state_d  = ST_IDLE;
        rr_ptr_d = idx_inc(owner_q);
      end
    end
  end

  // Credit counter: a send consumes a slot, credit_in returns one; a return
  // with the counter already full is dropped and flagged stickily.
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    case ({send, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CR_MAX) overflow_d = 1'b1;
        else                     credits_d  = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      credits_q  <= CR_MAX;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign grant        = gnt;
  assign send_out     = send;
  assign is_tail_out  = gnt_tail;
  assign locked       = (state_q == ST_LOCKED);
  assign owner        = owner_q;
  assign credits      = credits_q;
  assign overflow_err = overflow_q;

  a_onehot : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    $onehot0(gnt));
  a_subreq : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    (gnt & ~req) == '0);
  a_crmax  : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    credits_q <= CR_MAX);
  a_owner  : assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
    (state_q == ST_LOCKED) |-> ((gnt & ~owner_oh) == '0));

endmodule
